// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory-side signals around mem_port_arbiter.
// The master modport is the arbiter's view; slave is the surrounding system's view.
interface mem_port_arbiter_if #(
  parameter int WORD_SIZE = 32
);
  localparam int BE_W = WORD_SIZE / 8;

  logic                 ifetch_req;
  logic [WORD_SIZE-1:0] ifetch_addr;
  logic [WORD_SIZE-1:0] ifetch_rdata;
  logic                 ifetch_valid;

  logic                 data_en;
  logic                 data_write;
  logic [BE_W-1:0]      data_byte_en;
  logic [WORD_SIZE-1:0] data_addr;
  logic [WORD_SIZE-1:0] data_wdata;
  logic [WORD_SIZE-1:0] data_rdata;
  logic                 data_valid;

  logic                 mem_req;
  logic                 mem_write;
  logic [BE_W-1:0]      mem_byte_en;
  logic [WORD_SIZE-1:0] mem_addr;
  logic [WORD_SIZE-1:0] mem_wdata;
  logic [WORD_SIZE-1:0] mem_rdata;
  logic                 mem_ack;

  logic                 bus_err;

  modport master (
    input  ifetch_req, ifetch_addr,
    output ifetch_rdata, ifetch_valid,
    input  data_en, data_write, data_byte_en, data_addr, data_wdata,
    output data_rdata, data_valid,
    output mem_req, mem_write, mem_byte_en, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack,
    output bus_err
  );

  modport slave (
    output ifetch_req, ifetch_addr,
    input  ifetch_rdata, ifetch_valid,
    output data_en, data_write, data_byte_en, data_addr, data_wdata,
    input  data_rdata, data_valid,
    input  mem_req, mem_write, mem_byte_en, mem_addr, mem_wdata,
    output mem_rdata, mem_ack,
    input  bus_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and load/store,
// with anti-starvation for fetch and an ack timeout that aborts a stuck request.
module mem_port_arbiter #(
  parameter int WORD_SIZE    = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int ACK_TIMEOUT  = 64
) (
  input logic                clk,
  input logic                reset,
  mem_port_arbiter_if.master bus
);
  localparam int BE_W     = WORD_SIZE / 8;
  localparam int STREAK_W = $clog2(STARVE_LIMIT + 1);
  localparam int TMO_W    = $clog2(ACK_TIMEOUT);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);
  localparam logic [TMO_W-1:0]    TMO_LAST   = TMO_W'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t               state_reg, state_next;
  logic                 mem_write_reg;
  logic [BE_W-1:0]      mem_byte_en_reg;
  logic [WORD_SIZE-1:0] mem_addr_reg;
  logic [WORD_SIZE-1:0] mem_wdata_reg;
  logic [STREAK_W-1:0]  streak_reg;
  logic [TMO_W-1:0]     timeout_reg;
  logic                 bus_err_reg;

  logic grant_d, grant_i, abort, busy;

  always_comb begin
    state_next = state_reg;
    grant_d    = 1'b0;
    grant_i    = 1'b0;
    abort      = 1'b0;
    case (state_reg)
      IDLE: begin
        // Data wins ties unless fetch has already lost STARVE_LIMIT grants in a row.
        if (bus.data_en && (streak_reg < STREAK_MAX || !bus.ifetch_req)) begin
          grant_d    = 1'b1;
          state_next = BUSY_D;
        end else if (bus.ifetch_req) begin
          grant_i    = 1'b1;
          state_next = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (bus.mem_ack) begin
          state_next = IDLE;
        end else if (timeout_reg == TMO_LAST) begin
          abort      = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      mem_write_reg   <= 1'b0;
      mem_byte_en_reg <= '0;
      mem_addr_reg    <= '0;
      mem_wdata_reg   <= '0;
      streak_reg      <= '0;
      timeout_reg     <= '0;
      bus_err_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (grant_d) begin
        mem_write_reg   <= bus.data_write;
        // Loads always read the full word; lane selection happens downstream.
        mem_byte_en_reg <= bus.data_write ? bus.data_byte_en : '1;
        mem_addr_reg    <= bus.data_addr;
        mem_wdata_reg   <= bus.data_wdata;
        timeout_reg     <= '0;
        if (!bus.ifetch_req)
          streak_reg <= '0;
        else if (streak_reg != STREAK_MAX)
          streak_reg <= streak_reg + 1'b1;
      end else if (grant_i) begin
        mem_write_reg   <= 1'b0;
        mem_byte_en_reg <= '1;
        mem_addr_reg    <= bus.ifetch_addr;
        timeout_reg     <= '0;
        streak_reg      <= '0;
      end else if (busy && !bus.mem_ack) begin
        timeout_reg <= timeout_reg + 1'b1;
      end
      if (abort)
        bus_err_reg <= 1'b1;
    end
  end

  assign busy            = (state_reg != IDLE);
  assign bus.mem_req     = busy;
  assign bus.mem_write   = mem_write_reg;
  assign bus.mem_byte_en = mem_byte_en_reg;
  assign bus.mem_addr    = mem_addr_reg;
  assign bus.mem_wdata   = mem_wdata_reg;
  assign bus.bus_err     = bus_err_reg;

  // Completion is combinational off the ack so the requester advances on the next edge.
  assign bus.ifetch_valid = (state_reg == BUSY_I) && bus.mem_ack && !reset;
  assign bus.data_valid   = (state_reg == BUSY_D) && bus.mem_ack && !reset;
  assign bus.ifetch_rdata = bus.ifetch_valid ? bus.mem_rdata : '0;
  assign bus.data_rdata   = bus.data_valid ? bus.mem_rdata : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, store/fetch tie, starvation,
// byte lanes, ack timeout and reset during a transaction.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic reset;
  int compared   = 0;
  int mismatched = 0;

  mem_port_arbiter_if #(.WORD_SIZE(32)) bus ();

  mem_port_arbiter #(
    .WORD_SIZE(32), .STARVE_LIMIT(4), .ACK_TIMEOUT(64)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.master)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs are driven and outputs read mid-cycle.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %-16s observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset            = 1'b1;
    bus.ifetch_req   = 1'b0;
    bus.ifetch_addr  = '0;
    bus.data_en      = 1'b0;
    bus.data_write   = 1'b0;
    bus.data_byte_en = '0;
    bus.data_addr    = '0;
    bus.data_wdata   = '0;
    bus.mem_rdata    = '0;
    bus.mem_ack      = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
    #1;
    chk("rst_memreq",  32'(bus.mem_req), 32'h0);
    chk("rst_memwr",   32'(bus.mem_write), 32'h0);
    chk("rst_buserr",  32'(bus.bus_err), 32'h0);
    chk("rst_addr",    bus.mem_addr, 32'h0);
    chk("rst_wdata",   bus.mem_wdata, 32'h0);
    chk("rst_be",      32'(bus.mem_byte_en), 32'h0);
    chk("rst_valids",  32'({bus.ifetch_valid, bus.data_valid}), 32'h0);

    // Fetch only, ack one cycle after MemReq rises.
    bus.ifetch_req  = 1'b1;
    bus.ifetch_addr = 32'h40;
    cyc();
    chk("f1_memreq", 32'(bus.mem_req), 32'h1);
    chk("f1_addr",   bus.mem_addr, 32'h40);
    chk("f1_be",     32'(bus.mem_byte_en), 32'hF);
    chk("f1_memwr",  32'(bus.mem_write), 32'h0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h00500093;
    #1;
    chk("f1_valid", 32'(bus.ifetch_valid), 32'h1);
    chk("f1_rdata", bus.ifetch_rdata, 32'h00500093);
    chk("f1_dvalid", 32'(bus.data_valid), 32'h0);
    cyc();
    bus.ifetch_req = 1'b0;
    bus.mem_ack    = 1'b0;
    #1;
    chk("f1_idle", 32'(bus.mem_req), 32'h0);
    chk("f1_novalid", 32'(bus.ifetch_valid), 32'h0);

    // Simultaneous fetch and store: store first, then fetch.
    bus.ifetch_req   = 1'b1;
    bus.ifetch_addr  = 32'h44;
    bus.data_en      = 1'b1;
    bus.data_write   = 1'b1;
    bus.data_byte_en = 4'b1111;
    bus.data_addr    = 32'h100;
    bus.data_wdata   = 32'hDEADBEEF;
    cyc();
    chk("sw_memwr", 32'(bus.mem_write), 32'h1);
    chk("sw_addr",  bus.mem_addr, 32'h100);
    chk("sw_wdata", bus.mem_wdata, 32'hDEADBEEF);
    chk("sw_be",    32'(bus.mem_byte_en), 32'hF);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h11111111;
    #1;
    chk("sw_dvalid", 32'(bus.data_valid), 32'h1);
    chk("sw_drdata", bus.data_rdata, 32'h11111111);
    chk("sw_ivalid", 32'(bus.ifetch_valid), 32'h0);
    cyc();
    bus.data_en = 1'b0;
    bus.mem_ack = 1'b0;
    #1;
    chk("sw_idle", 32'(bus.mem_req), 32'h0);
    cyc();
    chk("f2_addr",  bus.mem_addr, 32'h44);
    chk("f2_memwr", 32'(bus.mem_write), 32'h0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h00A00113;
    #1;
    chk("f2_valid", 32'(bus.ifetch_valid), 32'h1);
    chk("f2_rdata", bus.ifetch_rdata, 32'h00A00113);
    cyc();
    bus.ifetch_req = 1'b0;
    bus.mem_ack    = 1'b0;

    // Five back-to-back loads with fetch waiting: the fifth grant goes to fetch.
    bus.ifetch_req  = 1'b1;
    bus.ifetch_addr = 32'h48;
    bus.data_en     = 1'b1;
    bus.data_write  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.data_addr = 32'h200 + 32'(4 * i);
      cyc();
      chk("ld_addr",  bus.mem_addr, 32'h200 + 32'(4 * i));
      chk("ld_memwr", 32'(bus.mem_write), 32'h0);
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'h1000 + 32'(i);
      #1;
      chk("ld_dvalid", 32'(bus.data_valid), 32'h1);
      chk("ld_drdata", bus.data_rdata, 32'h1000 + 32'(i));
      cyc();
      bus.mem_ack = 1'b0;
    end
    bus.data_addr = 32'h210;
    cyc();
    chk("starve_addr", bus.mem_addr, 32'h48);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h00000013;
    #1;
    chk("starve_ivalid", 32'(bus.ifetch_valid), 32'h1);
    chk("starve_dvalid", 32'(bus.data_valid), 32'h0);
    cyc();
    bus.ifetch_req = 1'b0;
    bus.mem_ack    = 1'b0;
    cyc();
    chk("ld5_addr", bus.mem_addr, 32'h210);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h5555AAAA;
    #1;
    chk("ld5_dvalid", 32'(bus.data_valid), 32'h1);
    chk("ld5_drdata", bus.data_rdata, 32'h5555AAAA);
    cyc();
    bus.data_en = 1'b0;
    bus.mem_ack = 1'b0;

    // SB forwards its lane mask; LB reads the full word.
    bus.data_en      = 1'b1;
    bus.data_write   = 1'b1;
    bus.data_byte_en = 4'b0001;
    bus.data_addr    = 32'h300;
    bus.data_wdata   = 32'h000000AB;
    cyc();
    chk("sb_be",    32'(bus.mem_byte_en), 32'h1);
    chk("sb_memwr", 32'(bus.mem_write), 32'h1);
    bus.mem_ack = 1'b1;
    cyc();
    bus.mem_ack    = 1'b0;
    bus.data_write = 1'b0;
    cyc();
    chk("lb_be",    32'(bus.mem_byte_en), 32'hF);
    chk("lb_memwr", 32'(bus.mem_write), 32'h0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h000000AB;
    #1;
    chk("lb_drdata", bus.data_rdata, 32'h000000AB);
    cyc();
    bus.data_en = 1'b0;
    bus.mem_ack = 1'b0;

    // Ack withheld for 64 BUSY cycles: abort, BusErr, then the held fetch is reissued.
    bus.ifetch_req  = 1'b1;
    bus.ifetch_addr = 32'h80;
    cyc();
    chk("to_memreq0", 32'(bus.mem_req), 32'h1);
    repeat (63) cyc();
    chk("to_memreq63", 32'(bus.mem_req), 32'h1);
    chk("to_buserr0",  32'(bus.bus_err), 32'h0);
    cyc();
    chk("to_buserr1", 32'(bus.bus_err), 32'h1);
    chk("to_memreqlo", 32'(bus.mem_req), 32'h0);
    chk("to_novalid", 32'(bus.ifetch_valid), 32'h0);
    cyc();
    chk("to_reissue", 32'(bus.mem_req), 32'h1);
    chk("to_readdr",  bus.mem_addr, 32'h80);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h00000113;
    #1;
    chk("to_ivalid", 32'(bus.ifetch_valid), 32'h1);
    chk("to_irdata", bus.ifetch_rdata, 32'h00000113);
    cyc();
    bus.ifetch_req = 1'b0;
    #1;
    chk("idle_ack_iv", 32'(bus.ifetch_valid), 32'h0);
    chk("idle_ack_dv", 32'(bus.data_valid), 32'h0);
    chk("to_sticky",   32'(bus.bus_err), 32'h1);
    cyc();
    bus.mem_ack = 1'b0;

    // Reset in the middle of a load; the late ack must not complete it.
    bus.data_en    = 1'b1;
    bus.data_write = 1'b0;
    bus.data_addr  = 32'h400;
    cyc();
    chk("rb_memreq", 32'(bus.mem_req), 32'h1);
    reset = 1'b1;
    cyc();
    reset       = 1'b0;
    bus.data_en = 1'b0;
    bus.mem_ack = 1'b1;
    #1;
    chk("rb_dvalid", 32'(bus.data_valid), 32'h0);
    chk("rb_memreq0", 32'(bus.mem_req), 32'h0);
    chk("rb_buserr", 32'(bus.bus_err), 32'h0);
    chk("rb_addr",   bus.mem_addr, 32'h0);
    cyc();
    bus.mem_ack = 1'b0;
    #1;
    chk("rb_idle", 32'(bus.mem_req), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
